// File: rtl/riscv_pkg.sv
// Shared RV32I register-file definitions for the writeback scoreboard slice.
package riscv_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] regidx_t;

    localparam regidx_t REG_X0 = 5'd0;

    function automatic logic is_x0(input regidx_t idx);
        return idx == REG_X0;
    endfunction

endpackage

// File: rtl/reg_busy_table.sv
// Pending-result bit per architectural register plus a registered count of set bits.
module reg_busy_table
    import riscv_pkg::*;
#(
    parameter int NREG = 32
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  set_en,
    input  regidx_t               set_idx,
    input  logic                  clr_en,
    input  regidx_t               clr_idx,
    output logic [NREG-1:0]       busy,
    output logic [REG_ADDR_W-1:0] busy_count
);

    logic [NREG-1:0] busy_nxt;
    logic            set_new;
    logic            clr_eff;

    // Count tracks only real bit transitions; a set on the clearing index wins.
    always_comb begin
        set_new  = set_en && !is_x0(set_idx) && !busy[set_idx];
        clr_eff  = clr_en && !is_x0(clr_idx) && busy[clr_idx]
                   && !(set_en && set_idx == clr_idx);
        busy_nxt = busy;
        if (clr_eff) begin
            busy_nxt[clr_idx] = 1'b0;
        end
        if (set_en && !is_x0(set_idx)) begin
            busy_nxt[set_idx] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy <= busy_nxt;
            case ({set_new, clr_eff})
                2'b10:   busy_count <= busy_count + 1'b1;
                2'b01:   busy_count <= busy_count - 1'b1;
                default: busy_count <= busy_count;
            endcase
        end
    end

endmodule

// File: rtl/regfile_wb_scoreboard.sv
// Writeback controller: drives the register file write port, tracks in-flight
// destinations, stalls issue on RAW/WAW hazards and bypasses same-cycle results.
module regfile_wb_scoreboard
    import riscv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  Issue_Valid,
    input  regidx_t               Issue_Rs1,
    input  regidx_t               Issue_Rs2,
    input  regidx_t               Issue_Rd,
    input  logic                  Issue_RdEn,
    output logic                  Issue_Stall,
    input  logic                  WB_Valid,
    input  regidx_t               WB_Rd,
    input  logic [XLEN-1:0]       WB_Data,
    output logic                  WB_Ready,
    output logic                  WE3,
    output regidx_t               A3,
    output logic [XLEN-1:0]       WD3,
    input  logic [XLEN-1:0]       RD1_In,
    input  logic [XLEN-1:0]       RD2_In,
    output logic [XLEN-1:0]       Op1,
    output logic [XLEN-1:0]       Op2,
    output logic [REG_ADDR_W-1:0] Busy_Count,
    output logic                  WB_Err
);

    logic [NREG-1:0] busy;
    logic            wb_fire;
    logic            haz_rs1;
    logic            haz_rs2;
    logic            haz_waw;
    logic            issue_fire;
    logic            set_en;
    logic            clr_en;

    always_comb begin
        WB_Ready = !Reset;
        wb_fire  = WB_Valid && WB_Ready;
        WE3      = wb_fire && !is_x0(WB_Rd);
        A3       = WB_Rd;
        WD3      = WB_Data;

        Op1 = (wb_fire && WB_Rd == Issue_Rs1 && !is_x0(Issue_Rs1)) ? WB_Data : RD1_In;
        Op2 = (wb_fire && WB_Rd == Issue_Rs2 && !is_x0(Issue_Rs2)) ? WB_Data : RD2_In;

        // A result landing this cycle resolves the hazard through the bypass.
        haz_rs1 = !is_x0(Issue_Rs1) && busy[Issue_Rs1] && !(wb_fire && WB_Rd == Issue_Rs1);
        haz_rs2 = !is_x0(Issue_Rs2) && busy[Issue_Rs2] && !(wb_fire && WB_Rd == Issue_Rs2);
        haz_waw = Issue_RdEn && !is_x0(Issue_Rd) && busy[Issue_Rd]
                  && !(wb_fire && WB_Rd == Issue_Rd);

        Issue_Stall = Issue_Valid && (haz_rs1 || haz_rs2 || haz_waw);
        issue_fire  = Issue_Valid && !Issue_Stall;
        set_en      = issue_fire && Issue_RdEn && !is_x0(Issue_Rd);
        clr_en      = wb_fire && !is_x0(WB_Rd);
    end

    reg_busy_table #(
        .NREG(NREG)
    ) u_busy (
        .CLK       (CLK),
        .Reset     (Reset),
        .set_en    (set_en),
        .set_idx   (Issue_Rd),
        .clr_en    (clr_en),
        .clr_idx   (WB_Rd),
        .busy      (busy),
        .busy_count(Busy_Count)
    );

    always_ff @(posedge CLK) begin
        if (Reset) begin
            WB_Err <= 1'b0;
        end else if (clr_en && !busy[WB_Rd]) begin
            WB_Err <= 1'b1;
        end
    end

endmodule
